elastic_pipe_reg: RTL

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/elastic_pipe_reg_ptr.sv | 37 +++
 rtl/elastic_pipe_reg.sv | 94 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and limits for the elastic pipeline register.
// Occupancy is decoded from the entry count.
package riscv_pkg;

  localparam int ELASTIC_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  function automatic state_t occ_state(input int cnt, input int depth);
    if (cnt == 0)
      return EMPTY;
    else if (cnt >= depth)
      return FULL;
    else
      return PARTIAL;
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_ptr.sv
// Modulo-DEPTH wrapping pointer.
// Clear has priority over increment so that a flush always lands on entry 0.
module elastic_ptr #(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_incr,
  output logic [PW-1:0] o_ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  // Explicit wrap compare so non-power-of-two depths work.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_clear)
      w_ptr_nxt = '0;
    else if (i_incr)
      w_ptr_nxt = (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= '0;
    else
      r_ptr <= w_ptr_nxt;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: small in-order buffer with flush and stall.
// Handshake outputs come from registered occupancy only; no bypass path.
module elastic_pipe_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  input  logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1 || DEPTH > ELASTIC_MAX_DEPTH || WIDTH < 1) begin : g_bad_params
    $fatal(1, "elastic_pipe_reg: illegal WIDTH=%0d / DEPTH=%0d", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  state_t           r_state;

  logic [CW-1:0]    w_count_nxt;
  logic [PW-1:0]    w_rd_ptr;
  logic [PW-1:0]    w_wr_ptr;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);

  // Flush squashes both sides of the handshake in the same cycle.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~stall & ~flush;

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_state <= EMPTY;
    end else begin
      r_count <= w_count_nxt;
      r_state <= occ_state(int'(w_count_nxt), DEPTH);
    end
  end

  // Payload storage is deliberately left unreset; the output mux hides it.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[w_wr_ptr] <= in_data;
  end

  elastic_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (flush),
    .i_incr  (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  elastic_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (flush),
    .i_incr  (w_push),
    .o_ptr   (w_wr_ptr)
  );

  assign out_data = out_valid ? r_mem[w_rd_ptr] : '0;
  assign count    = r_count;

endmodule
